// File: rtl/scroll_display_mux.sv
// Scrolling multiplexed segment display: message buffer, scroll offset and digit refresh.
// pattern/LED are registered one cycle behind sel/pos/buffer; free-running, no backpressure.
module scroll_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int MSG_LEN     = 10,
  parameter int SEG_W       = 8,
  parameter int SCROLL_DIV  = 50_000_000,
  parameter int REFRESH_DIV = 5_000,
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  dir,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [SEG_W-1:0]      wr_data,
  output logic [SEG_W-1:0]      pattern,
  output logic [NUM_DIGITS-1:0] LED,
  output logic [AW-1:0]         pos,
  output logic                  step
);

  localparam int SCW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int RCW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SLW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int IW   = $clog2(MSG_LEN + NUM_DIGITS) + 1;
  localparam int NSUB = (NUM_DIGITS + MSG_LEN - 1) / MSG_LEN;

  localparam logic [SCW-1:0]        SCNT_LAST = SCW'(SCROLL_DIV - 1);
  localparam logic [RCW-1:0]        RCNT_LAST = RCW'(REFRESH_DIV - 1);
  localparam logic [SLW-1:0]        SEL_LAST  = SLW'(NUM_DIGITS - 1);
  localparam logic [AW-1:0]         POS_LAST  = AW'(MSG_LEN - 1);
  localparam logic [IW-1:0]         LEN_IDX   = IW'(MSG_LEN);
  localparam logic [AW:0]           LEN_ADDR  = (AW + 1)'(MSG_LEN);
  localparam logic [NUM_DIGITS-1:0] LED_RST   = ~NUM_DIGITS'(1);

  logic [SEG_W-1:0]      msg_buf [MSG_LEN];
  logic [SCW-1:0]        scnt;
  logic [RCW-1:0]        rcnt;
  logic [SLW-1:0]        sel;
  logic                  tick;
  logic                  wr_ok;
  logic [AW-1:0]         pos_nxt;
  logic [AW-1:0]         rd_idx;
  logic [IW-1:0]         idx_sum;
  logic [NUM_DIGITS-1:0] led_nxt;

  assign tick  = run && (scnt == SCNT_LAST);
  assign wr_ok = wr_en && ({1'b0, wr_addr} < LEN_ADDR);

  // Scroll divider only advances while running, so a pause resumes mid-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= '0;
    end else if (tick) begin
      scnt <= '0;
    end else if (run) begin
      scnt <= scnt + SCW'(1);
    end
  end

  always_comb begin
    pos_nxt = pos;
    if (dir) begin
      pos_nxt = (pos == '0) ? POS_LAST : pos - AW'(1);
    end else begin
      pos_nxt = (pos == POS_LAST) ? '0 : pos + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos  <= '0;
      step <= 1'b0;
    end else begin
      step <= tick;
      if (tick) begin
        pos <= pos_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
      sel  <= '0;
    end else if (rcnt == RCNT_LAST) begin
      rcnt <= '0;
      sel  <= (sel == SEL_LAST) ? '0 : sel + SLW'(1);
    end else begin
      rcnt <= rcnt + RCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_buf[i] <= '0;
      end
    end else if (wr_ok) begin
      msg_buf[wr_addr] <= wr_data;
    end
  end

  // pos+sel stays below MSG_LEN+NUM_DIGITS, so a few conditional subtracts replace a modulo.
  always_comb begin
    idx_sum = IW'(pos) + IW'(sel);
    for (int i = 0; i < NSUB; i++) begin
      if (idx_sum >= LEN_IDX) begin
        idx_sum = idx_sum - LEN_IDX;
      end
    end
    rd_idx = AW'(idx_sum);
  end

  always_comb begin
    led_nxt      = '1;
    led_nxt[sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= '0;
      LED     <= LED_RST;
    end else begin
      pattern <= msg_buf[rd_idx];
      LED     <= led_nxt;
    end
  end

endmodule
